// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: opcode/funct codes, default
// latencies, and the E-stage decode helper.
package md_unit_pkg;

  localparam logic [5:0] SPECIAL_OP = 6'h00;

  localparam logic [5:0] MFHI_S  = 6'h10;
  localparam logic [5:0] MTHI_S  = 6'h11;
  localparam logic [5:0] MFLO_S  = 6'h12;
  localparam logic [5:0] MTLO_S  = 6'h13;
  localparam logic [5:0] MULT_S  = 6'h18;
  localparam logic [5:0] MULTU_S = 6'h19;
  localparam logic [5:0] DIV_S   = 6'h1a;
  localparam logic [5:0] DIVU_S  = 6'h1b;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    OpNone,
    OpMult,
    OpMultu,
    OpDiv,
    OpDivu,
    OpMfhi,
    OpMflo,
    OpMthi,
    OpMtlo
  } md_op_e;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  function automatic md_op_e md_decode(logic [5:0] opcode, logic [5:0] funct);
    md_op_e op;
    op = OpNone;
    if (opcode == SPECIAL_OP) begin
      unique case (funct)
        MULT_S:  op = OpMult;
        MULTU_S: op = OpMultu;
        DIV_S:   op = OpDiv;
        DIVU_S:  op = OpDivu;
        MFHI_S:  op = OpMfhi;
        MFLO_S:  op = OpMflo;
        MTHI_S:  op = OpMthi;
        MTLO_S:  op = OpMtlo;
        default: op = OpNone;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage operand/instruction bundle into md_unit and its HI/LO read, busy and
// stall outputs back to the pipeline.
interface md_unit_if;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        in_d_uses_hilo;
  logic [31:0] out_hilo_rdata;
  logic        out_busy;
  logic        out_stall;

  modport master (
    output in_instr, in_rs_val, in_rt_val, in_d_uses_hilo,
    input  out_hilo_rdata, out_busy, out_stall
  );

  modport slave (
    input  in_instr, in_rs_val, in_rt_val, in_d_uses_hilo,
    output out_hilo_rdata, out_busy, out_stall
  );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers. Results are computed at
// launch, held in pend_*, and committed to HI/LO after a fixed latency.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  md_op_e      op;
  logic        is_md, busy, start;
  logic [31:0] rs, rt, rt_nz;
  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;

  assign rs    = bus.in_rs_val;
  assign rt    = bus.in_rt_val;
  assign op    = md_decode(bus.in_instr[31:26], bus.in_instr[5:0]);
  assign is_md = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  assign busy  = (cnt_q != 4'd0);
  assign start = is_md && !busy;

  // Divisor forced nonzero so the divider never evaluates x/0; the zero case is
  // handled explicitly below by keeping HI/LO.
  assign rt_nz  = (rt == 32'd0) ? 32'd1 : rt;
  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (op)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        if (rt != 32'd0) begin
          res_lo = 32'($signed(rs) / $signed(rt_nz));
          res_hi = 32'($signed(rs) % $signed(rt_nz));
        end
      end
      OpDivu: begin
        if (rt != 32'd0) begin
          res_lo = rs / rt_nz;
          res_hi = rs % rt_nz;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StBusy;
          cnt_d     = ((op == OpMult) || (op == OpMultu)) ? MultCnt : DivCnt;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
        end else if (op == OpMthi) begin
          hi_d = rs;
        end else if (op == OpMtlo) begin
          lo_d = rs;
        end
      end
      StBusy: begin
        // MTHI/MTLO and new starts are dropped here; the stall keeps them out.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.out_busy       = busy;
  assign bus.out_stall      = bus.in_d_uses_hilo && (busy || start);
  assign bus.out_hilo_rdata = (op == OpMfhi) ? hi_q :
                              (op == OpMflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO are queued at launch and
// compared via MFHI/MFLO once the busy period ends.
module tb_md_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  hilo_t       sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  function automatic hilo_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi0, input logic [31:0] lo0);
    hilo_t       r;
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    r.hi = hi0;
    r.lo = lo0;
    sa = int'(a);
    sb = int'(b);
    case (f)
      F_MULT: begin
        ps = longint'(sa) * longint'(sb);
        r.hi = ps[63:32];
        r.lo = ps[31:0];
      end
      F_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        r.hi = pu[63:32];
        r.lo = pu[31:0];
      end
      F_DIV: if (b != 32'd0) begin
        r.lo = 32'(sa / sb);
        r.hi = 32'(sa % sb);
      end
      F_DIVU: if (b != 32'd0) begin
        r.lo = a / b;
        r.hi = a % b;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.in_instr = rtype(F_MFHI);
    #1 check_eq({tag, "_hi"}, bus.out_hilo_rdata, exp_hi);
    bus.in_instr = rtype(F_MFLO);
    #1 check_eq({tag, "_lo"}, bus.out_hilo_rdata, exp_lo);
    bus.in_instr = NOP;
    #1;
  endtask

  // Called shortly after a rising edge; leaves the bench shortly after a later edge.
  task automatic launch(input string tag, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int cycles);
    hilo_t e;
    int    n;
    bit    stall_ok;
    bus.in_instr       = rtype(f);
    bus.in_rs_val      = rs;
    bus.in_rt_val      = rt;
    bus.in_d_uses_hilo = 1'b1;
    #1;
    check_eq({tag, "_busy_pre"}, 32'(bus.out_busy), 32'd0);
    check_eq({tag, "_stall_start"}, 32'(bus.out_stall), 32'd1);
    e.hi = exp_hi;
    e.lo = exp_lo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_instr = rtype(F_MFHI);
    #1 check_eq({tag, "_uncommitted"}, bus.out_hilo_rdata, m_hi);
    n = 0;
    stall_ok = 1'b1;
    while (bus.out_busy && n < 40) begin
      n++;
      if (bus.out_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_busy_cycles"}, 32'(n), 32'(cycles));
    check_eq({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    check_eq({tag, "_stall_after"}, 32'(bus.out_stall), 32'd0);
    bus.in_d_uses_hilo = 1'b0;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      read_hilo(tag, e.hi, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    hilo_t       r;
    logic [5:0]  fl[4];
    logic [5:0]  f;
    logic [31:0] a, b;
    fl[0] = F_MULT;
    fl[1] = F_MULTU;
    fl[2] = F_DIV;
    fl[3] = F_DIVU;
    m_hi = 32'd0;
    m_lo = 32'd0;

    bus.in_instr       = NOP;
    bus.in_rs_val      = 32'd0;
    bus.in_rt_val      = 32'd0;
    bus.in_d_uses_hilo = 1'b1;
    #1;
    check_eq("rst_busy", 32'(bus.out_busy), 32'd0);
    check_eq("rst_stall_nop", 32'(bus.out_stall), 32'd0);
    bus.in_instr = rtype(F_MULT);
    #1 check_eq("rst_stall_start", 32'(bus.out_stall), 32'd1);
    bus.in_d_uses_hilo = 1'b0;
    bus.in_instr = rtype(F_MFLO);
    #1 check_eq("rst_mflo", bus.out_hilo_rdata, 32'd0);
    bus.in_instr = NOP;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    launch("mult", F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    launch("multu", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    launch("div", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    launch("divu0", F_DIVU, 32'h0000_0007, 32'h0000_0000, m_hi, m_lo, 10);

    @(posedge clk);
    #1;
    bus.in_instr  = rtype(F_MTHI);
    bus.in_rs_val = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.in_instr  = rtype(F_MTLO);
    bus.in_rs_val = 32'hCAFE_F00D;
    #1 check_eq("mthi_1cyc", bus.out_hilo_rdata, 32'd0);
    @(posedge clk);
    #1;
    m_hi = 32'h1234_5678;
    m_lo = 32'hCAFE_F00D;
    read_hilo("mthi_mtlo", m_hi, m_lo);

    for (int i = 0; i < 6; i++) begin
      f = fl[$urandom_range(0, 3)];
      a = $urandom;
      b = (i == 2) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 100)) : $urandom);
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      r = model(f, a, b, m_hi, m_lo);
      launch($sformatf("rnd%0d", i), f, a, b, r.hi, r.lo,
             (f == F_MULT || f == F_MULTU) ? 5 : 10);
    end

    // Abort a MULT with reset three cycles in.
    bus.in_instr  = rtype(F_MULT);
    bus.in_rs_val = 32'd9;
    bus.in_rt_val = 32'd9;
    @(posedge clk);
    #1;
    bus.in_instr = NOP;
    repeat (2) @(posedge clk);
    #1 check_eq("abort_busy_pre", 32'(bus.out_busy), 32'd1);
    reset = 1'b0;
    #1 check_eq("abort_busy_async", 32'(bus.out_busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_eq("abort_no_commit", 32'(bus.out_busy), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    read_hilo("abort", 32'd0, 32'd0);

    launch("post_rst", F_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit and HI/LO register file for the five-stage MIPS pipeline. It is the consumer end of the E-stage `Will_Use_hilo` traffic. It decodes the instruction currently held in E and launches MULT/MULTU/DIV/DIVU with fixed multi-cycle latency. It services MTHI/MTLO writes and MFHI/MFLO reads, and raises the pipeline stall request while D holds a HI/LO instruction that must wait.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `in_instr`  in  32  instruction currently in the E stage.
- `in_rs_val`  in  32  forwarded rs operand (E stage).
- `in_rt_val`  in  32  forwarded rt operand (E stage).
- `in_d_uses_hilo`  in  1  D-stage instruction is one of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- `out_hilo_rdata`  out  32  HI for MFHI in E, LO for MFLO in E, else 0.
- `out_busy`  out  1  operation in flight.
- `out_stall`  out  1  stall request to the hazard unit.

## Operation
- Decode from `in_instr` using the shared opcode/funct macros: `Special` opcode with funct MULT_S, MULTU_S, DIV_S, DIVU_S, MFHI_S, MFLO_S, MTHI_S, MTLO_S. `start` = E instruction is MULT/MULTU/DIV/DIVU and `out_busy`==0.
- On `start`, the result is computed from `in_rs_val`/`in_rt_val` and latched into `pend_hi`/`pend_lo`:
  - MULT: signed 64-bit product, {HI,LO}.
  - MULTU: unsigned 64-bit product, {HI,LO}.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divisor 0: `pend_hi`/`pend_lo` are loaded with current HI/LO. The busy period still runs and HI/LO end unchanged.
- Counter `cnt`, 4 bits:
  - On `start`, loaded with MULT_CYCLES or DIV_CYCLES.
  - While nonzero, decrements each edge.
  - On the edge where `cnt`==1, HI<=`pend_hi`, LO<=`pend_lo`, and `cnt`->0.
- `out_busy` = (`cnt`!=0).
- MTHI/MTLO in E with `out_busy`==0: HI (resp. LO) <= `in_rs_val` at next edge. While busy, MTHI/MTLO and new starts are ignored. The stall contract makes that case unreachable; it is kept as a defensive rule.
- `out_hilo_rdata`: combinational from the HI/LO registers. It does not reflect an uncommitted pending result.
- `out_stall` = `in_d_uses_hilo` & (`out_busy` | `start`). Combinational, no registered delay.
- States: IDLE (`cnt`==0) and BUSY (`cnt`!=0).
  - IDLE->BUSY on `start`.
  - BUSY->IDLE at the commit edge.
  - The commit edge does not accept a new start in the same cycle. A start becomes possible the following cycle.

## Timing
- Reset (async, `reset`==0): HI=0, LO=0, `pend_hi`=0, `pend_lo`=0, `cnt`=0. Outputs: `out_busy`=0; `out_stall`=`in_d_uses_hilo`&`start`; `out_hilo_rdata` follows decode on zero HI/LO.
- A MULT sampled at edge T0 gives `out_busy`=1 during cycles T0+1..T0+5, with HI/LO updated at edge T0+5. DIV is the same with 10 cycles.
- MTHI at edge T0 makes HI visible from T0+1 (one-cycle latency).
- Reset asserted mid-operation aborts it: there is no commit and the pending result is discarded.

## Structure
- Add to the shared constant header: `MULT_CYCLES_DEF` 5 and `DIV_CYCLES_DEF` 10. The header already holds the funct macros, including MTHI_S, MTLO_S, MFHI_S and MFLO_S.
- Single module, no sub-module. Arithmetic uses `$signed`/unsigned `*`, `/`, `%` at 32 bits, with products widened to 64.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged after 10 cycles.
- MTHI rs=0x12345678 then MFHI -> `out_hilo_rdata`=0x12345678 one cycle later. MFLO after reset -> 0.
- `in_d_uses_hilo`=1 while a DIV starts -> `out_stall`=1 from the start cycle through the last busy cycle, and 0 in the cycle after commit.
- Pull `reset` low 3 cycles into a MULT -> `out_busy` drops asynchronously and HI/LO=0 after release.
